// File: rtl/tpu_job_sequencer.sv
// tpu_job_sequencer: bus master that feeds one tpuv1 instance.
// Per job it streams A (8 words), B (8 words) and C (16 words, or zeros)
// into the TPU, fires MatMul, waits a fixed settle time, then streams the
// 16 result words of C back out with a valid/ready handshake.
// Optional feature: define TPU_SEQ_PERF_EN to add the perf_cycles output,
// a saturating count of busy cycles for the most recent job.
module tpu_job_sequencer #(
  parameter int DIM         = 8,
  parameter int DATAW       = 64,
  parameter int ADDRW       = 16,
  parameter int WAIT_CYCLES = DIM*3+2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_c_zero,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DATAW-1:0] res_data,
  output logic             res_last,
  output logic             busy
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  localparam int WW = $clog2(WAIT_CYCLES+1);
  localparam logic [3:0] AB_LAST = 4'(DIM-1);
  localparam logic [3:0] C_LAST  = 4'(2*DIM-1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES-1);
  localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'(16'h0400);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_C,
    S_START,
    S_WAIT,
    S_READ
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            c_zero_q, c_zero_d;
  logic [ADDRW-1:0] idx_off;

  // Each word is 8 bytes apart in the TPU map; idx selects the word.
  assign idx_off = ADDRW'({idx_q, 3'b000});

  // Next-state and bus drive; the write path from in_data is combinational so
  // a word reaches the TPU in the same cycle it is handshaken.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    c_zero_d  = c_zero_q;
    job_ready = 1'b0;
    in_ready  = 1'b0;
    tpu_r_w   = 1'b0;
    tpu_addr  = '0;
    tpu_wdata = '0;
    res_valid = 1'b0;
    res_data  = '0;
    res_last  = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          c_zero_d = job_c_zero;
          idx_d    = '0;
          state_d  = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = A_BASE + idx_off;
          tpu_wdata = in_data;
          if (idx_q == AB_LAST) begin
            idx_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = B_BASE + idx_off;
          tpu_wdata = in_data;
          if (idx_q == AB_LAST) begin
            idx_d   = '0;
            state_d = S_LOAD_C;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_LOAD_C: begin
        in_ready = !c_zero_q;
        if (c_zero_q || in_valid) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = C_BASE + idx_off;
          tpu_wdata = c_zero_q ? '0 : in_data;
          if (idx_q == C_LAST) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_START: begin
        tpu_r_w  = 1'b1;
        tpu_addr = MM_ADDR;
        wait_d   = '0;
        idx_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          idx_d   = '0;
          state_d = S_READ;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_READ: begin
        tpu_addr  = C_BASE + idx_off;
        res_valid = 1'b1;
        res_data  = tpu_rdata;
        res_last  = (idx_q == C_LAST);
        if (res_ready) begin
          if (idx_q == C_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer state register; reset aborts any job in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wait_q   <= '0;
      c_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      c_zero_q <= c_zero_d;
    end
  end

`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter: restarts at job accept, saturates, holds while idle.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (job_valid) perf_d = '0;
    end else if (perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Perf counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb_tpu_job_sequencer: drives jobs into tpu_job_sequencer against a
// behavioural tpuv1 model; expected bus writes and result words are queued
// when a job is generated and popped by a monitor on the opposite clock edge.
module tb_tpu_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic        job_c_zero = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_wdata;
  logic [63:0] tpu_rdata;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [63:0] res_data;
  logic        res_last;
  logic        busy;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  tpu_job_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_c_zero(job_c_zero),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy)
`ifdef TPU_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  typedef struct { logic [15:0] addr; logic [63:0] data; } wr_t;
  typedef struct { logic [15:0] addr; logic [63:0] data; logic last; } rd_t;

  wr_t exp_wr[$];
  rd_t exp_rd[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  res_seen = 0;
  int  start_cyc = 0;
  int  hold_cnt = 0;
  int  exp_hold = 1;
  bit  wait_armed = 1'b0;
  bit  job_active = 1'b0;

  logic [511:0]  job_a, job_b;
  logic [1023:0] job_c;

  // Matrix model: C[r][c] += sum_k A[r][k]*B[k][c]; A/B bytes, C 16-bit, all unsigned, wrapping.
  function automatic logic [1023:0] ref_mac(logic [511:0] a, logic [511:0] b, logic [1023:0] c);
    logic [1023:0] res;
    logic [15:0]   acc;
    for (int r = 0; r < 8; r++)
      for (int col = 0; col < 8; col++) begin
        acc = c[128*r + 16*col +: 16];
        for (int k = 0; k < 8; k++)
          acc = acc + 16'(a[64*r + 8*k +: 8]) * 16'(b[64*k + 8*col +: 8]);
        res[128*r + 16*col +: 16] = acc;
      end
    return res;
  endfunction

  // Behavioural tpuv1: A/B rows, C rows latched lo then committed on hi, MatMul at 0x0400.
  logic [511:0]  a_flat = '0, b_flat = '0;
  logic [1023:0] c_flat = '0;
  logic [63:0]   c_lo = '0;

  always @(posedge clk) begin
    if (rst_n && tpu_r_w) begin
      case (tpu_addr[15:8])
        8'h01: a_flat[64*tpu_addr[5:3] +: 64] <= tpu_wdata;
        8'h02: b_flat[64*tpu_addr[5:3] +: 64] <= tpu_wdata;
        8'h03: if (!tpu_addr[3]) c_lo <= tpu_wdata;
               else c_flat[128*tpu_addr[6:4] +: 128] <= {tpu_wdata, c_lo};
        8'h04: c_flat <= ref_mac(a_flat, b_flat, c_flat);
        default: ;
      endcase
    end
  end

  assign tpu_rdata = (tpu_addr[15:8] == 8'h03) ? c_flat[64*tpu_addr[6:3] +: 64] : 64'h0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: compares every bus write and result word against the queued expectations.
  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    cyc++;
    if (rst_n) begin
      if (job_valid && job_ready) begin
        checkOutput("accept_while_active", 64'(job_active), 64'd0);
        job_active = 1'b1;
      end
      if (tpu_r_w) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL spurious_write actual addr=%0h expected no write", tpu_addr);
        end else begin
          w = exp_wr.pop_front();
          checkOutput("wr_addr", 64'(tpu_addr), 64'(w.addr));
          checkOutput("wr_data", tpu_wdata, w.data);
          if (w.addr == 16'h0400) begin
            start_cyc = cyc;
            wait_armed = 1'b1;
          end
        end
      end
      if (res_valid) begin
        if (wait_armed) begin
          checkOutput("wait_gap", 64'(cyc - start_cyc), 64'd27);
          wait_armed = 1'b0;
        end
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL spurious_result actual addr=%0h expected no result", tpu_addr);
        end else begin
          checkOutput("rd_addr", 64'(tpu_addr), 64'(exp_rd[0].addr));
          if (tpu_addr == 16'h0328) hold_cnt++;
          if (res_ready) begin
            r = exp_rd.pop_front();
            checkOutput("res_data", res_data, r.data);
            checkOutput("res_last", 64'(res_last), 64'(r.last));
            if (r.addr == 16'h0328) begin
              checkOutput("hold_0328", 64'(hold_cnt), 64'(exp_hold));
              hold_cnt = 0;
            end
            res_seen++;
            if (r.last) job_active = 1'b0;
          end
        end
      end
    end
  end

  // Build one job's data and queue the bus writes and results it must produce.
  task automatic prepJob(input int mode, input bit cz);
    wr_t w;
    rd_t r;
    logic [1023:0] res;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        1: begin job_a[64*i +: 64] = 64'h1 << (8*i); job_b[64*i +: 64] = {8{8'(i+1)}}; end
        2: begin job_a[64*i +: 64] = {8{8'h01}};     job_b[64*i +: 64] = {8{8'h01}}; end
        default: begin job_a[64*i +: 64] = {$urandom, $urandom}; job_b[64*i +: 64] = {$urandom, $urandom}; end
      endcase
    end
    for (int i = 0; i < 16; i++)
      job_c[64*i +: 64] = (mode == 2) ? {4{16'h0001}} : {$urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      w.addr = 16'h0100 + 16'(8*i); w.data = job_a[64*i +: 64]; exp_wr.push_back(w);
    end
    for (int i = 0; i < 8; i++) begin
      w.addr = 16'h0200 + 16'(8*i); w.data = job_b[64*i +: 64]; exp_wr.push_back(w);
    end
    for (int i = 0; i < 16; i++) begin
      w.addr = 16'h0300 + 16'(8*i); w.data = cz ? 64'h0 : job_c[64*i +: 64]; exp_wr.push_back(w);
    end
    w.addr = 16'h0400; w.data = 64'h0; exp_wr.push_back(w);
    res = ref_mac(job_a, job_b, cz ? 1024'h0 : job_c);
    for (int i = 0; i < 16; i++) begin
      r.addr = 16'h0300 + 16'(8*i); r.data = res[64*i +: 64]; r.last = (i == 15);
      exp_rd.push_back(r);
    end
  endtask

  task automatic acceptJob(input bit cz, input bit keep);
    bit ok = 1'b0;
    job_valid = 1'b1;
    job_c_zero = cz;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (job_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      total++; bad++;
      $display("[TB] FAIL job_accept actual=timeout expected=accept");
    end
    if (!keep) job_valid = 1'b0;
  endtask

  task automatic feedWord(input logic [63:0] data, input bit gaps);
    bit ok = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = {$urandom, $urandom};
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data = data;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      total++; bad++;
      $display("[TB] FAIL in_handshake actual=timeout expected=accept");
    end
  endtask

  // Run one full job: accept, stream operands, then drain results (optionally stalling word 5).
  task automatic applyStimulus(input int mode, input bit cz, input bit gaps, input bit stall,
                               input bit keep, input bit junk);
    int target;
    int stall_left;
    prepJob(mode, cz);
    exp_hold = stall ? 4 : 1;
    target = res_seen + 16;
    acceptJob(cz, keep);
    for (int i = 0; i < 8; i++) feedWord(job_a[64*i +: 64], gaps);
    for (int i = 0; i < 8; i++) feedWord(job_b[64*i +: 64], gaps);
    if (!cz) for (int i = 0; i < 16; i++) feedWord(job_c[64*i +: 64], gaps);
    in_valid = junk;
    in_data = {$urandom | 32'h1, $urandom};
    stall_left = stall ? 3 : 0;
    res_ready = 1'b1;
    for (int t = 0; t < 3000 && res_seen < target; t++) begin
      @(posedge clk); #1;
      if (res_valid && tpu_addr == 16'h0328 && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = 1'b1;
      end
    end
    checkOutput("results_done", 64'(res_seen), 64'(target));
    in_valid = 1'b0;
    res_ready = 1'b1;
    if (!keep) begin
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_job_ready", 64'(job_ready), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_job_ready", 64'(job_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_r_w", 64'(tpu_r_w), 64'd0);
    checkOutput("rst_addr", 64'(tpu_addr), 64'd0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    @(posedge clk); #1;

    // Identity, zero C, no stalls: also the minimum-length job.
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef TPU_SEQ_PERF_EN
    checkOutput("perf_cycles", 64'(perf_cycles), 64'd75);
    @(posedge clk); #1;
    checkOutput("perf_hold", 64'(perf_cycles), 64'd75);
`endif
    // Accumulate into preloaded C, with input gaps.
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Random data with input gaps, result stall on word 5, stray in_valid afterwards.
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Abort mid LOAD_B with an asynchronous reset.
    prepJob(0, 1'b0);
    acceptJob(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) feedWord(job_a[64*i +: 64], 1'b1);
    for (int i = 0; i < 3; i++) feedWord(job_b[64*i +: 64], 1'b1);
    in_valid = 1'b1;
    in_data = job_b[64*3 +: 64];
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_r_w", 64'(tpu_r_w), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_job_ready", 64'(job_ready), 64'd1);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
    exp_wr.delete();
    exp_rd.delete();
    job_active = 1'b0;
    wait_armed = 1'b0;
    hold_cnt = 0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // job_valid held high across two jobs.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised jobs.
    for (int j = 0; j < 4; j++)
      applyStimulus(0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0,
                    1'($urandom_range(0, 1)));

    repeat (5) @(posedge clk);
    #1;
    checkOutput("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    checkOutput("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
